multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Multi-cycle sequencer for the CPU datapath (ALU, reg file, ext unit, NPC, data memory).
//  Steps each instruction through IF/ID/EXE/MEM/WB and drives the datapath control lines per state.
//  Stalls on a memory ready handshake and counts retired instructions.
//  Datapath mux semantics: ALUsrcA 1=rs, 0=shamt; ALUsrcB 1=rt & Rw=rd, 0=imm32 & Rw=rt; memRd 1=Dout.
// PARAMETERS
//  CNT_WIDTH  32  width of retired-instruction counter (wraps modulo 2^CNT_WIDTH)
//  WAIT_MAX   15  max mem_ready wait cycles per access before timeout (1..255)
// PORTS
//  clk        in   1   system clock, rising edge
//  reset      in   1   asynchronous, active-low reset
//  op         in   6   instruction[31:26] from IR, valid from ID onward
//  funct      in   6   instruction[5:0] from IR
//  zero       in   1   ALU zero flag (valid in EXE)
//  mem_ready  in   1   memory access complete (IF fetch or MEM data access)
//  mem_req    out  1   memory access request, IF and MEM states
//  ir_wrt     out  1   latch instruction register
//  PCwrt      out  1   update PC
//  jump       out  1   NPC selects jump target
//  branch     out  1   NPC selects PC+4+(imm32<<2)
//  regWrt     out  1   reg file write enable
//  memWrt     out  1   data memory write enable
//  memRd      out  1   writeback selects memory data
//  ALUsrcA    out  1   ALU A select
//  ALUsrcB    out  1   ALU B / Rw select
//  ALUctr     out  3   000 add,001 sub,010 and,011 or,100 sll,101 slt
//  extOp      out  1   1=sign-extend, 0=zero-extend imm16
//  state      out  3   current state (debug)
//  retired    out  CNT_WIDTH  retired-instruction count
//  halted     out  1   sticky, HALT state reached
//  illegal    out  1   sticky, undecoded op/funct seen
//  timeout    out  1   sticky, mem_ready timeout
// BEHAVIOUR
//  States: IF=000 ID=001 EXE=010 MEM=011 WB=100 HALT=101; reset -> IF; all sticky flags, retired,
//   wait counter = 0. Control outputs are combinational from state+op/funct+zero, all 0 while reset low.
//  IF: mem_req=1; on mem_ready: ir_wrt=1, ->ID; else wait. ID: decode, next per class below.
//  Decode: op 000000 R-type funct 100000 add,100010 sub,100100 and,100101 or,000000 sll,101010 slt;
//   001000 addi(sext,add), 001101 ori(zext,or), 001010 slti(sext,slt), 100011 lw, 101011 sw (sext,add),
//   000100 beq, 000101 bne (sext,sub), 000010 j, 111111 halt.
//  Paths (zero-wait cycles): R/I-ALU IF,ID,EXE,WB=4; lw IF,ID,EXE,MEM,WB=5; sw IF,ID,EXE,MEM=4;
//   beq/bne IF,ID,EXE=3; j IF,ID=2; halt IF,ID->HALT.
//  EXE: ALUsrcA/B, ALUctr, extOp for the op; sll uses ALUsrcA=0, ALUsrcB=1.
//  MEM: mem_req=1; sw holds memWrt=1 until mem_ready; lw holds memRd=1; advance on mem_ready.
//  WB: regWrt=1 for one cycle; lw also memRd=1; R-type ALUsrcB=1, I-type ALUsrcB=0.
//  PCwrt=1 exactly once per instruction, in its final state: WB (ALU, lw), MEM on mem_ready (sw),
//   EXE (beq/bne), ID (j, with jump=1). branch=1 with PCwrt when beq&zero or bne&!zero.
//  retired += 1 on every cycle PCwrt=1; wraps all-ones -> 0 silently.
//  Illegal op/funct in ID: illegal<=1, treated as NOP: PCwrt=1 in ID, ->IF, retired++.
//  HALT: all enables 0, halted=1, stays until reset. halt op does not increment retired.
//  Wait counter clears on entering IF/MEM and counts each cycle mem_ready=0; reaching WAIT_MAX
//   with mem_ready still 0 -> timeout<=1, ->HALT, no PCwrt/memWrt side effect after that cycle.
//  mem_ready outside IF/MEM is ignored. reset low mid-instruction: immediate return to IF, counters cleared.
// TESTING
//  Reset low then high, mem_ready=1 -> state=000, retired=0, all enables 0, then ir_wrt pulse in cycle 1.
//  add (op 0, funct 100000), zero-wait -> states 0,1,2,4; regWrt=1 & PCwrt=1 in cycle 4; retired=1.
//  lw with mem_ready low 2 cycles in MEM -> MEM held 3 cycles, memRd=1 throughout, retired=1 after WB.
//  beq zero=1 -> branch=1,PCwrt=1 in EXE; bne zero=1 -> branch=0,PCwrt=1; j -> jump=1,PCwrt=1 in ID.
//  op 111111 -> HALT in cycle 3, halted=1, no outputs after; op 110011 -> illegal=1, retired++.
//  WAIT_MAX=15, mem_ready held 0 in IF -> timeout=1, state=101 after 15 wait cycles; reset clears.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle IF/ID/EXE/MEM/WB sequencer for the single-issue CPU datapath.
// Handles memory ready stalls with a bounded wait, retired-instruction counting and sticky status.
module multicycle_controller #(
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned WAIT_MAX  = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 ir_wrt,
    output logic                 PCwrt,
    output logic                 jump,
    output logic                 branch,
    output logic                 regWrt,
    output logic                 memWrt,
    output logic                 memRd,
    output logic                 ALUsrcA,
    output logic                 ALUsrcB,
    output logic [2:0]           ALUctr,
    output logic                 extOp,
    output logic [2:0]           state,
    output logic [CNT_WIDTH-1:0] retired,
    output logic                 halted,
    output logic                 illegal,
    output logic                 timeout
);

    typedef enum logic [2:0] {
        StIf   = 3'b000,
        StId   = 3'b001,
        StExe  = 3'b010,
        StMem  = 3'b011,
        StWb   = 3'b100,
        StHalt = 3'b101
    } state_e;

    typedef enum logic [3:0] {
        ClsRAlu,
        ClsIAlu,
        ClsLw,
        ClsSw,
        ClsBeq,
        ClsBne,
        ClsJ,
        ClsHalt,
        ClsIllegal
    } cls_e;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSll = 3'b100;
    localparam logic [2:0] AluSlt = 3'b101;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_e               r_state;
    state_e               w_state_nxt;
    logic [7:0]           r_wait;
    logic [7:0]           w_wait_nxt;
    logic [CNT_WIDTH-1:0] r_retired;
    logic                 r_halted;
    logic                 r_illegal;
    logic                 r_timeout;
    logic                 w_set_illegal;
    logic                 w_set_timeout;

    cls_e                 w_cls;
    logic [2:0]           w_dec_alu;
    logic                 w_dec_ext;
    logic                 w_dec_sll;

    logic                 w_mem_req;
    logic                 w_ir_wrt;
    logic                 w_pcwrt;
    logic                 w_jump;
    logic                 w_branch;
    logic                 w_reg_wrt;
    logic                 w_mem_wrt;
    logic                 w_mem_rd;
    logic                 w_src_a;
    logic                 w_src_b;
    logic [2:0]           w_alu_ctr;
    logic                 w_ext_op;

    // Instruction decode; op/funct come straight from the IR and stay stable after ID.
    always_comb begin
        w_cls     = ClsIllegal;
        w_dec_alu = AluAdd;
        w_dec_ext = 1'b0;
        w_dec_sll = 1'b0;
        unique case (op)
            6'b000000: begin
                w_cls = ClsRAlu;
                unique case (funct)
                    6'b100000: w_dec_alu = AluAdd;
                    6'b100010: w_dec_alu = AluSub;
                    6'b100100: w_dec_alu = AluAnd;
                    6'b100101: w_dec_alu = AluOr;
                    6'b000000: begin
                        w_dec_alu = AluSll;
                        w_dec_sll = 1'b1;
                    end
                    6'b101010: w_dec_alu = AluSlt;
                    default:   w_cls = ClsIllegal;
                endcase
            end
            6'b001000: begin
                w_cls     = ClsIAlu;
                w_dec_alu = AluAdd;
                w_dec_ext = 1'b1;
            end
            6'b001101: begin
                w_cls     = ClsIAlu;
                w_dec_alu = AluOr;
            end
            6'b001010: begin
                w_cls     = ClsIAlu;
                w_dec_alu = AluSlt;
                w_dec_ext = 1'b1;
            end
            6'b100011: begin
                w_cls     = ClsLw;
                w_dec_ext = 1'b1;
            end
            6'b101011: begin
                w_cls     = ClsSw;
                w_dec_ext = 1'b1;
            end
            6'b000100: begin
                w_cls     = ClsBeq;
                w_dec_alu = AluSub;
                w_dec_ext = 1'b1;
            end
            6'b000101: begin
                w_cls     = ClsBne;
                w_dec_alu = AluSub;
                w_dec_ext = 1'b1;
            end
            6'b000010: w_cls = ClsJ;
            6'b111111: w_cls = ClsHalt;
            default:   w_cls = ClsIllegal;
        endcase
    end

    // Next state and per-state datapath controls.
    always_comb begin
        w_state_nxt   = r_state;
        w_wait_nxt    = 8'd0;
        w_set_illegal = 1'b0;
        w_set_timeout = 1'b0;
        w_mem_req     = 1'b0;
        w_ir_wrt      = 1'b0;
        w_pcwrt       = 1'b0;
        w_jump        = 1'b0;
        w_branch      = 1'b0;
        w_reg_wrt     = 1'b0;
        w_mem_wrt     = 1'b0;
        w_mem_rd      = 1'b0;
        w_src_a       = 1'b0;
        w_src_b       = 1'b0;
        w_alu_ctr     = AluAdd;
        w_ext_op      = 1'b0;
        unique case (r_state)
            StIf: begin
                w_mem_req = 1'b1;
                if (mem_ready) begin
                    w_ir_wrt    = 1'b1;
                    w_state_nxt = StId;
                end else if (r_wait == WAIT_LAST) begin
                    w_set_timeout = 1'b1;
                    w_state_nxt   = StHalt;
                end else begin
                    w_wait_nxt = r_wait + 8'd1;
                end
            end
            StId: begin
                unique case (w_cls)
                    ClsRAlu, ClsIAlu, ClsLw, ClsSw, ClsBeq, ClsBne: w_state_nxt = StExe;
                    ClsJ: begin
                        w_pcwrt     = 1'b1;
                        w_jump      = 1'b1;
                        w_state_nxt = StIf;
                    end
                    ClsHalt: w_state_nxt = StHalt;
                    default: begin
                        // Undecodable instruction retires as a NOP.
                        w_set_illegal = 1'b1;
                        w_pcwrt       = 1'b1;
                        w_state_nxt   = StIf;
                    end
                endcase
            end
            StExe: begin
                w_alu_ctr = w_dec_alu;
                w_ext_op  = w_dec_ext;
                w_src_a   = !w_dec_sll;
                w_src_b   = (w_cls == ClsRAlu) || (w_cls == ClsBeq) || (w_cls == ClsBne);
                unique case (w_cls)
                    ClsRAlu, ClsIAlu: w_state_nxt = StWb;
                    ClsLw, ClsSw:     w_state_nxt = StMem;
                    ClsBeq: begin
                        w_pcwrt     = 1'b1;
                        w_branch    = zero;
                        w_state_nxt = StIf;
                    end
                    ClsBne: begin
                        w_pcwrt     = 1'b1;
                        w_branch    = !zero;
                        w_state_nxt = StIf;
                    end
                    default: w_state_nxt = StIf;
                endcase
            end
            StMem: begin
                w_mem_req = 1'b1;
                w_mem_wrt = (w_cls == ClsSw);
                w_mem_rd  = (w_cls == ClsLw);
                if (mem_ready) begin
                    if (w_cls == ClsSw) begin
                        w_pcwrt     = 1'b1;
                        w_state_nxt = StIf;
                    end else begin
                        w_state_nxt = StWb;
                    end
                end else if (r_wait == WAIT_LAST) begin
                    w_set_timeout = 1'b1;
                    w_state_nxt   = StHalt;
                end else begin
                    w_wait_nxt = r_wait + 8'd1;
                end
            end
            StWb: begin
                w_reg_wrt   = 1'b1;
                w_pcwrt     = 1'b1;
                w_mem_rd    = (w_cls == ClsLw);
                w_src_b     = (w_cls == ClsRAlu);
                w_state_nxt = StIf;
            end
            StHalt: w_state_nxt = StHalt;
            default: w_state_nxt = StIf;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= StIf;
            r_wait    <= 8'd0;
            r_retired <= '0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
            if (w_pcwrt) begin
                r_retired <= r_retired + CNT_WIDTH'(1);
            end
            if (w_state_nxt == StHalt) begin
                r_halted <= 1'b1;
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
            if (w_set_timeout) begin
                r_timeout <= 1'b1;
            end
        end
    end

    // Controls are forced low while reset is asserted even though the state register sits in IF.
    assign mem_req = w_mem_req & reset;
    assign ir_wrt  = w_ir_wrt & reset;
    assign PCwrt   = w_pcwrt & reset;
    assign jump    = w_jump & reset;
    assign branch  = w_branch & reset;
    assign regWrt  = w_reg_wrt & reset;
    assign memWrt  = w_mem_wrt & reset;
    assign memRd   = w_mem_rd & reset;
    assign ALUsrcA = w_src_a & reset;
    assign ALUsrcB = w_src_b & reset;
    assign ALUctr  = reset ? w_alu_ctr : 3'b000;
    assign extOp   = w_ext_op & reset;

    assign state   = r_state;
    assign retired = r_retired;
    assign halted  = r_halted;
    assign illegal = r_illegal;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: instruction vector table with a completion
// scoreboard, plus directed sequences for memory stalls, halt, timeout, reset and counter wrap.
module tb_multicycle_controller;

    localparam int unsigned CW = 4;
    localparam int unsigned WM = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [5:0]    op = 6'd0;
    logic [5:0]    funct = 6'd0;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req;
    logic          ir_wrt;
    logic          PCwrt;
    logic          jump;
    logic          branch;
    logic          regWrt;
    logic          memWrt;
    logic          memRd;
    logic          ALUsrcA;
    logic          ALUsrcB;
    logic [2:0]    ALUctr;
    logic          extOp;
    logic [2:0]    state;
    logic [CW-1:0] retired;
    logic          halted;
    logic          illegal;
    logic          timeout;

    multicycle_controller #(
        .CNT_WIDTH(CW),
        .WAIT_MAX (WM)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .funct    (funct),
        .zero     (zero),
        .mem_ready(mem_ready),
        .mem_req  (mem_req),
        .ir_wrt   (ir_wrt),
        .PCwrt    (PCwrt),
        .jump     (jump),
        .branch   (branch),
        .regWrt   (regWrt),
        .memWrt   (memWrt),
        .memRd    (memRd),
        .ALUsrcA  (ALUsrcA),
        .ALUsrcB  (ALUsrcB),
        .ALUctr   (ALUctr),
        .extOp    (extOp),
        .state    (state),
        .retired  (retired),
        .halted   (halted),
        .illegal  (illegal),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         cycles;
        logic [2:0] fin_state;
        logic       chk_alu;
        logic [2:0] alu;
        logic       chk_ext;
        logic       ext;
        logic       chk_src;
        logic       srca;
        logic       srcb;
        logic       branch;
        logic       jump;
        logic       regw;
        logic       memrd;
        logic       ill;
    } vec_t;

    localparam int NV = 19;
    vec_t          vecs[NV];
    vec_t          exp_q[$];
    int            n_chk = 0;
    int            n_pass = 0;
    logic [CW-1:0] exp_ret = '0;
    logic          exp_ill = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [5:0] o, input logic [5:0] f, input logic z,
                                input int cyc, input logic [2:0] fs, input logic ca,
                                input logic [2:0] a, input logic ce, input logic e,
                                input logic cs, input logic sa, input logic sb, input logic br,
                                input logic jp, input logic rw, input logic mr, input logic il);
        vec_t v;
        v.op = o; v.funct = f; v.zero = z; v.cycles = cyc; v.fin_state = fs;
        v.chk_alu = ca; v.alu = a; v.chk_ext = ce; v.ext = e;
        v.chk_src = cs; v.srca = sa; v.srcb = sb;
        v.branch = br; v.jump = jp; v.regw = rw; v.memrd = mr; v.ill = il;
        return v;
    endfunction

    // Run one zero-wait instruction; expected completion record is queued and popped on PCwrt.
    task automatic run_vec(input int i);
        vec_t       v;
        vec_t       e;
        int         cyc;
        bit         done;
        bit         saw_exe;
        logic [2:0] alu_s;
        logic       ext_s;
        logic       sa_s;
        logic       sb_s;
        v = vecs[i];
        op = v.op;
        funct = v.funct;
        zero = v.zero;
        mem_ready = 1'b1;
        exp_q.push_back(v);
        alu_s = 3'b000; ext_s = 1'b0; sa_s = 1'b0; sb_s = 1'b0;
        saw_exe = 1'b0;
        #1;
        chk($sformatf("v%0d_start_state", i), 32'(state), 32'd0);
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < 20) begin
            cyc++;
            if (state == 3'b010) begin
                saw_exe = 1'b1;
                alu_s = ALUctr; ext_s = extOp; sa_s = ALUsrcA; sb_s = ALUsrcB;
            end
            if (PCwrt) begin
                done = 1'b1;
                if (exp_q.size() == 0) begin
                    chk($sformatf("v%0d_sb_empty", i), 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("v%0d_cycles", i), 32'(cyc), 32'(e.cycles));
                    chk($sformatf("v%0d_fin_state", i), 32'(state), 32'(e.fin_state));
                    chk($sformatf("v%0d_branch", i), 32'(branch), 32'(e.branch));
                    chk($sformatf("v%0d_jump", i), 32'(jump), 32'(e.jump));
                    chk($sformatf("v%0d_regwrt", i), 32'(regWrt), 32'(e.regw));
                    chk($sformatf("v%0d_memrd", i), 32'(memRd), 32'(e.memrd));
                    if (e.chk_alu) begin
                        chk($sformatf("v%0d_saw_exe", i), 32'(saw_exe), 32'd1);
                        chk($sformatf("v%0d_aluctr", i), 32'(alu_s), 32'(e.alu));
                    end
                    if (e.chk_ext) chk($sformatf("v%0d_extop", i), 32'(ext_s), 32'(e.ext));
                    if (e.chk_src) begin
                        chk($sformatf("v%0d_srca", i), 32'(sa_s), 32'(e.srca));
                        chk($sformatf("v%0d_srcb", i), 32'(sb_s), 32'(e.srcb));
                    end
                    exp_ill = exp_ill | e.ill;
                end
            end
            @(negedge clk);
            #1;
        end
        if (!done) chk($sformatf("v%0d_no_pcwrt", i), 32'd0, 32'd1);
        exp_ret = exp_ret + 1'b1;
        chk($sformatf("v%0d_retired", i), 32'(retired), 32'(exp_ret));
        chk($sformatf("v%0d_back_in_if", i), 32'(state), 32'd0);
        chk($sformatf("v%0d_illegal", i), 32'(illegal), 32'(exp_ill));
    endtask

    // Load/store with mem_ready low for the first two MEM cycles.
    task automatic mem_wait(input bit is_lw);
        int mem_cyc;
        int guard;
        op = is_lw ? 6'b100011 : 6'b101011;
        funct = 6'd0;
        mem_ready = 1'b1;
        #1;
        guard = 0;
        while (state != 3'b011 && guard < 10) begin
            @(negedge clk);
            #1;
            guard++;
        end
        mem_cyc = 0;
        while (state == 3'b011 && guard < 20) begin
            mem_ready = (mem_cyc >= 2);
            #1;
            if (is_lw) begin
                chk($sformatf("lw_memrd_c%0d", mem_cyc), 32'(memRd), 32'd1);
                chk($sformatf("lw_pcwrt_c%0d", mem_cyc), 32'(PCwrt), 32'd0);
            end else begin
                chk($sformatf("sw_memwrt_c%0d", mem_cyc), 32'(memWrt), 32'd1);
                chk($sformatf("sw_pcwrt_c%0d", mem_cyc), 32'(PCwrt), 32'(mem_cyc == 2));
            end
            chk($sformatf("mem_req_c%0d", mem_cyc), 32'(mem_req), 32'd1);
            mem_cyc++;
            @(negedge clk);
            #1;
            guard++;
        end
        chk(is_lw ? "lw_mem_cycles" : "sw_mem_cycles", 32'(mem_cyc), 32'd3);
        if (is_lw) begin
            chk("lw_wb_state", 32'(state), 32'd4);
            chk("lw_wb_memrd", 32'(memRd), 32'd1);
            chk("lw_wb_regwrt", 32'(regWrt), 32'd1);
            chk("lw_wb_pcwrt", 32'(PCwrt), 32'd1);
            @(negedge clk);
            #1;
        end
        exp_ret = exp_ret + 1'b1;
        chk(is_lw ? "lw_retired" : "sw_retired", 32'(retired), 32'(exp_ret));
        chk(is_lw ? "lw_back_if" : "sw_back_if", 32'(state), 32'd0);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_flags", 32'({halted, illegal, timeout}), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        exp_ret = '0;
        exp_ill = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    initial begin
        //            op         funct      z  cyc fs    ca a       ce e     cs sa sb  br jp rw mr il
        vecs[0]  = mk(6'b000000, 6'b100000, 0, 4, 3'd4, 1, 3'b000, 0, 0,    1, 1, 1,  0, 0, 1, 0, 0);
        vecs[1]  = mk(6'b000000, 6'b100010, 0, 4, 3'd4, 1, 3'b001, 0, 0,    1, 1, 1,  0, 0, 1, 0, 0);
        vecs[2]  = mk(6'b000000, 6'b100100, 0, 4, 3'd4, 1, 3'b010, 0, 0,    1, 1, 1,  0, 0, 1, 0, 0);
        vecs[3]  = mk(6'b000000, 6'b100101, 0, 4, 3'd4, 1, 3'b011, 0, 0,    1, 1, 1,  0, 0, 1, 0, 0);
        vecs[4]  = mk(6'b000000, 6'b000000, 0, 4, 3'd4, 1, 3'b100, 0, 0,    1, 0, 1,  0, 0, 1, 0, 0);
        vecs[5]  = mk(6'b000000, 6'b101010, 0, 4, 3'd4, 1, 3'b101, 0, 0,    1, 1, 1,  0, 0, 1, 0, 0);
        vecs[6]  = mk(6'b001000, 6'b000000, 0, 4, 3'd4, 1, 3'b000, 1, 1,    1, 1, 0,  0, 0, 1, 0, 0);
        vecs[7]  = mk(6'b001101, 6'b111111, 0, 4, 3'd4, 1, 3'b011, 1, 0,    1, 1, 0,  0, 0, 1, 0, 0);
        vecs[8]  = mk(6'b001010, 6'b000000, 0, 4, 3'd4, 1, 3'b101, 1, 1,    1, 1, 0,  0, 0, 1, 0, 0);
        vecs[9]  = mk(6'b100011, 6'b000000, 0, 5, 3'd4, 1, 3'b000, 1, 1,    1, 1, 0,  0, 0, 1, 1, 0);
        vecs[10] = mk(6'b101011, 6'b000000, 0, 4, 3'd3, 1, 3'b000, 1, 1,    1, 1, 0,  0, 0, 0, 0, 0);
        vecs[11] = mk(6'b000100, 6'b000000, 1, 3, 3'd2, 1, 3'b001, 1, 1,    0, 0, 0,  1, 0, 0, 0, 0);
        vecs[12] = mk(6'b000100, 6'b000000, 0, 3, 3'd2, 1, 3'b001, 1, 1,    0, 0, 0,  0, 0, 0, 0, 0);
        vecs[13] = mk(6'b000101, 6'b000000, 1, 3, 3'd2, 1, 3'b001, 1, 1,    0, 0, 0,  0, 0, 0, 0, 0);
        vecs[14] = mk(6'b000101, 6'b000000, 0, 3, 3'd2, 1, 3'b001, 1, 1,    0, 0, 0,  1, 0, 0, 0, 0);
        vecs[15] = mk(6'b000010, 6'b000000, 0, 2, 3'd1, 0, 3'b000, 0, 0,    0, 0, 0,  0, 1, 0, 0, 0);
        vecs[16] = mk(6'b000000, 6'b000001, 0, 2, 3'd1, 0, 3'b000, 0, 0,    0, 0, 0,  0, 0, 0, 0, 1);
        vecs[17] = mk(6'b110011, 6'b000000, 0, 2, 3'd1, 0, 3'b000, 0, 0,    0, 0, 0,  0, 0, 0, 0, 1);
        vecs[18] = mk(6'b000010, 6'b000000, 1, 2, 3'd1, 0, 3'b000, 0, 0,    0, 0, 0,  0, 1, 0, 0, 0);

        reset = 1'b0;
        mem_ready = 1'b1;
        #12;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_enables", 32'({mem_req, ir_wrt, PCwrt, jump, branch, regWrt, memWrt, memRd,
                                ALUsrcA, ALUsrcB, ALUctr, extOp}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("c1_ir_wrt", 32'(ir_wrt), 32'd1);
        chk("c1_mem_req", 32'(mem_req), 32'd1);

        for (int i = 0; i < NV; i++) run_vec(i);

        mem_wait(1'b1);
        mem_wait(1'b0);

        // halt: IF, ID, then HALT in cycle 3 with everything quiet
        op = 6'b111111;
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("halt_c2_state", 32'(state), 32'd1);
        @(negedge clk);
        #1;
        chk("halt_c3_state", 32'(state), 32'd5);
        chk("halt_flag", 32'(halted), 32'd1);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("halt_quiet_%0d", k), 32'({mem_req, ir_wrt, PCwrt, regWrt, memWrt}),
                32'd0);
            @(negedge clk);
            #1;
        end
        chk("halt_state_held", 32'(state), 32'd5);
        chk("halt_no_retire", 32'(retired), 32'(exp_ret));
        pulse_reset();

        // timeout: mem_ready never arrives in IF
        mem_ready = 1'b0;
        op = 6'b000000;
        funct = 6'b100000;
        for (int k = 1; k < int'(WM); k++) begin
            @(negedge clk);
            #1;
        end
        chk("to_still_if", 32'(state), 32'd0);
        chk("to_not_yet", 32'(timeout), 32'd0);
        @(negedge clk);
        #1;
        chk("to_state", 32'(state), 32'd5);
        chk("to_flag", 32'(timeout), 32'd1);
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("to_stays_halt", 32'(state), 32'd5);
        chk("to_no_req", 32'(mem_req), 32'd0);
        pulse_reset();

        // reset mid-instruction during EXE
        op = 6'b000000;
        funct = 6'b100000;
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        chk("mid_in_exe", 32'(state), 32'd2);
        pulse_reset();

        // counter wrap with a 4-bit counter
        for (int k = 0; k < 16; k++) run_vec(15);
        chk("wrap_zero", 32'(retired), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
